// File: rtl/divider_iterative.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
// Optional early completion for b == 0 or a < b when DIVIDER_EARLY_OUT_EN is defined.
module divider_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_step;
  logic             q_bit;
  logic             early;
  logic             unused_rem_msb;

  // Acceptance decode and one restoring-division step.
  always_comb begin
    accept    = valid_in && (state_q != BUSY);
    last_iter = (cnt_q == CW'(WIDTH - 1));
    shifted   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    rem_step  = shifted;
    q_bit     = 1'b0;
    if (shifted >= {1'b0, dvs_q}) begin
      rem_step = shifted - {1'b0, dvs_q};
      q_bit    = 1'b1;
    end
`ifdef DIVIDER_EARLY_OUT_EN
    early = (b == '0) || (a < b);
`else
    early = 1'b0;
`endif
    // After a subtract the remainder is below b, so the stored MSB is always zero.
    unused_rem_msb = rem_q[WIDTH];
  end

  // FSM and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= early ? DONE : BUSY;
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CW'(1);
      if (last_iter) begin
        state_q <= DONE;
      end
    end
  end

  // Operand latch and datapath; registers only move on accept or while BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      dvs_q <= b;
      if (early) begin
        dvd_q <= (b == '0) ? '1 : '0;
        rem_q <= {1'b0, a};
      end else begin
        dvd_q <= a;
        rem_q <= '0;
      end
    end else if (state_q == BUSY) begin
      dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
      rem_q <= rem_step;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    valid_out = (state_q == DONE);
    busy      = (state_q == BUSY);
    q         = dvd_q;
    r         = rem_q[WIDTH-1:0];
  end

endmodule

// File: tb/tb_divider_iterative.sv
// Directed and pseudo-random self-checking bench for divider_iterative (WIDTH = 32).
module tb_divider_iterative;

  localparam int unsigned W = 32;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         valid_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid_out;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;

  int checks = 0;
  int errors = 0;

  divider_iterative #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .q         (q),
    .r         (r),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair, then check latency, flags and result.
  task automatic run_div(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
    int lat;
    lat = (EarlyOut && (bv == '0 || av < bv)) ? 0 : W;
    @(negedge clk);
    valid_in = 1'b1;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (lat > 0) begin
      check({tag, "_drop"}, {31'd0, valid_out}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      repeat (lat - 1) @(posedge clk);
      #1;
      check({tag, "_pre"}, {31'd0, valid_out}, 32'd0);
      @(posedge clk);
      #1;
    end else begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    end
    check({tag, "_vo"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rq;
    logic [W-1:0] rr;
    reset    = 1'b1;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vo", {31'd0, valid_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_div("basic", 32'd100, 32'd7, 32'd14, 32'd2);
    // Still holding in DONE one cycle later.
    @(posedge clk);
    #1;
    check("hold_vo", {31'd0, valid_out}, 32'd1);
    check("hold_q", q, 32'd14);
    check("hold_r", r, 32'd2);

    // Back-to-back from DONE.
    run_div("b2b", 32'd50, 32'd6, 32'd8, 32'd2);
    run_div("div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run_div("max1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_div("maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_div("altb", 32'd3, 32'd10, 32'd0, 32'd3);

    // Operands presented mid-division must be ignored.
    @(negedge clk);
    valid_in = 1'b1;
    a        = 32'd1000;
    b        = 32'd10;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    valid_in = 1'b1;
    a        = 32'd9;
    b        = 32'd3;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    repeat (W - 6) @(posedge clk);
    #1;
    check("ign_pre", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    #1;
    check("ign_vo", {31'd0, valid_out}, 32'd1);
    check("ign_q", q, 32'd100);
    check("ign_r", r, 32'd0);

    // Reset in the middle of a division.
    @(negedge clk);
    valid_in = 1'b1;
    a        = 32'd12345;
    b        = 32'd17;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_vo", {31'd0, valid_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_q", q, 32'd0);
    check("mid_rst_r", r, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    check("mid_rst_never", {31'd0, valid_out}, 32'd0);
    run_div("post_rst", 32'd81, 32'd9, 32'd9, 32'd0);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == '0) begin
        rq = '1;
        rr = ra;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
      end
      run_div("rand", ra, rb, rq, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_iterative.md
DIVIDER_ITERATIVE -- requirements
Module: divider_iterative

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  1  operand-valid strobe, sampled on rising clk edges.
REQ-005 SHALL have port a  input  WIDTH  unsigned dividend, sampled with valid_in.
REQ-006 SHALL have port b  input  WIDTH  unsigned divisor, sampled with valid_in.
REQ-007 SHALL have port valid_out  output  1  high while q and r hold a completed result.
REQ-008 SHALL have port q  output  WIDTH  quotient, floor(a/b).
REQ-009 SHALL have port r  output  WIDTH  remainder, a - q*b.
REQ-010 SHALL have port busy  output  1  high while a division is in progress.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL accept operands on a rising edge where valid_in=1 and state is IDLE or DONE, and SHALL latch a and b on that edge.
REQ-013 SHALL ignore valid_in while BUSY; latched operands and the iteration count SHALL be unaffected.
REQ-014 On acceptance, SHALL enter BUSY with the iteration counter at 0, and SHALL deassert valid_out from that edge.
REQ-015 SHALL perform restoring division, one quotient bit per BUSY cycle, MSB first: shift partial remainder left one bit and bring in the next dividend bit; subtract b if the result is >= b and set the quotient bit; otherwise keep the shifted value and clear the bit.
REQ-016 SHALL hold the partial remainder in WIDTH+1 bits so that the compare and subtract never overflow.
REQ-017 SHALL move from BUSY to DONE on the edge that completes iteration WIDTH-1. For acceptance at edge N, valid_out SHALL be high after edge N+WIDTH (latency WIDTH cycles).
REQ-018 In DONE, SHALL hold q, r and valid_out=1 stable until the next acceptance or reset.
REQ-019 q and r SHALL be don't-care while valid_out=0, and SHALL be registered (not combinational) when valid_out=1.
REQ-020 When b=0, SHALL produce q = all ones and r = a, with normal latency.
REQ-021 When a < b, SHALL produce q = 0 and r = a.
REQ-022 An acceptance in DONE SHALL start a new division on the same edge, with no idle cycle.
REQ-023 busy SHALL equal (state == BUSY).

Reset
REQ-024 Asserting reset at any time, including mid-division, SHALL immediately force state=IDLE, valid_out=0, busy=0, q=0, r=0 and counter=0.
REQ-025 The first acceptance SHALL be possible on the first rising edge after reset deasserts.
REQ-026 A division in progress when reset asserts SHALL be discarded and SHALL never produce valid_out.

Configuration
REQ-027 Macro DIVIDER_EARLY_OUT_EN SHALL control early completion.
- Defined: an acceptance with b=0 or a<b SHALL go directly to DONE on the accepting edge, with q and r per REQ-020/REQ-021 (latency 1 cycle, busy never asserts).
- Undefined: every division SHALL take exactly WIDTH cycles.

Verification
REQ-028 Basic division: a=100, b=7, valid_in for one cycle -> valid_out high exactly WIDTH cycles after acceptance, with q=14, r=2.
REQ-029 Divide by zero: a=5, b=0 -> q=32'hFFFFFFFF, r=5.
- Latency is 32 cycles without DIVIDER_EARLY_OUT_EN and 1 cycle with it.
REQ-030 Maximum values: a=32'hFFFFFFFF, b=1 -> q=32'hFFFFFFFF, r=0.
- Also a=32'hFFFFFFFF, b=32'hFFFFFFFF -> q=1, r=0.
REQ-031 Ignore while busy: a=1000, b=10 accepted; at cycle 5 drive valid_in=1 with a=9, b=3 -> result is q=100, r=0, delivered at the original latency.
REQ-032 Reset mid-division: assert reset at cycle 10 of a division -> valid_out=0 and busy=0 immediately; a new division a=81, b=9 after reset -> q=9, r=0.
REQ-033 Back-to-back: in DONE, assert valid_in with a=50, b=6 -> valid_out drops the next cycle; the result q=8, r=2 appears WIDTH cycles later.
- Additionally run 200 pseudo-random pairs and compare each result against a/b and a%b.
